// File: rtl/masked_pkg.sv
// ----------------------------------------------------------------------------
// masked_pkg: shared helpers for the HPC3 masked multiplier (pair indexing).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package masked_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef logic [DEF_WIDTH-1:0] share_t;

  function automatic int unsigned npair(input int unsigned shares);
    return shares * (shares - 1) / 2;
  endfunction

  // Unordered pair index; r_ji and p_ji alias r_ij and p_ij.
  function automatic int unsigned pair_idx(input int unsigned i,
                                           input int unsigned j,
                                           input int unsigned shares);
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * shares - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hpc3_cross_term.sv
// ----------------------------------------------------------------------------
// hpc3_cross_term: registered HPC3 cross-domain term (areg & v) ^ w.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hpc3_cross_term #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_j,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] term
);

  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] w_q, w_d;

  assign v_d    = b_j ^ r;
  assign areg_d = a_i;
  assign w_d    = (~a_i & r) ^ p;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      areg_q <= '0;
      w_q    <= '0;
    end else if (load) begin
      v_q    <= v_d;
      areg_q <= areg_d;
      w_q    <= w_d;
    end
  end

  assign term = (areg_q & v_q) ^ w_q;

endmodule

`default_nettype wire

// File: rtl/masked_hpc3_mult_pipe.sv
// ----------------------------------------------------------------------------
// masked_hpc3_mult_pipe: HPC3 masked AND over SHARES shares, 2-stage valid/ready.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module masked_hpc3_mult_pipe
  import masked_pkg::*;
#(
  parameter  int unsigned SHARES = 4,
  parameter  int unsigned WIDTH  = 8,
  localparam int unsigned NPAIR  = npair(SHARES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SHARES*WIDTH-1:0] a,
  input  logic [SHARES*WIDTH-1:0] b,
  input  logic [NPAIR*WIDTH-1:0]  r,
  input  logic [NPAIR*WIDTH-1:0]  p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SHARES*WIDTH-1:0] c
);

  logic                    s1_valid_q, s1_valid_d;
  logic                    out_valid_q, out_valid_d;
  logic [SHARES*WIDTH-1:0] u_q, u_d;
  logic [SHARES*WIDTH-1:0] c_q, c_d;
  logic                    accept;
  logic                    s2_load;
  logic                    s1_adv;
  logic [WIDTH-1:0]        term [SHARES][SHARES];
  logic [WIDTH-1:0]        acc;

  assign s2_load  = ~out_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_load;
  assign in_ready = ~s1_valid_q | s2_load;
  assign accept   = in_valid & in_ready;

  assign s1_valid_d  = accept | (s1_valid_q & ~s1_adv);
  assign out_valid_d = s1_adv | (out_valid_q & ~out_ready);

  assign u_d = a & b;

  // Diagonal slots are tied to zero so the XOR tree can walk every j in order.
  for (genvar gi = 0; gi < SHARES; gi++) begin : g_share
    for (genvar gj = 0; gj < SHARES; gj++) begin : g_peer
      if (gi == gj) begin : g_diag
        assign term[gi][gj] = '0;
      end else begin : g_cross
        localparam int unsigned K = pair_idx(gi, gj, SHARES);
        hpc3_cross_term #(
          .WIDTH (WIDTH)
        ) u_term (
          .clk  (clk),
          .rst  (rst),
          .load (accept),
          .a_i  (a[gi*WIDTH +: WIDTH]),
          .b_j  (b[gj*WIDTH +: WIDTH]),
          .r    (r[K*WIDTH +: WIDTH]),
          .p    (p[K*WIDTH +: WIDTH]),
          .term (term[gi][gj])
        );
      end
    end
  end

  always_comb begin
    c_d = '0;
    acc = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      acc = u_q[i*WIDTH +: WIDTH];
      for (int unsigned j = 0; j < SHARES; j++) begin
        acc = acc ^ term[i][j];
      end
      c_d[i*WIDTH +: WIDTH] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      u_q         <= '0;
      c_q         <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (accept) u_q <= u_d;
      if (s1_adv) c_q <= c_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;

endmodule

`default_nettype wire

// File: tb/tb_masked_hpc3_mult_pipe.sv
// ----------------------------------------------------------------------------
// tb_masked_hpc3_mult_pipe: directed and scoreboarded checks of the masked multiplier.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_masked_hpc3_mult_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default configuration: SHARES=4, WIDTH=8
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, c;
  logic [47:0] r = '0, p = '0;

  masked_hpc3_mult_pipe #(.SHARES(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .r(r), .p(p),
    .out_valid(out_valid), .out_ready(out_ready), .c(c)
  );

  // SHARES=2, WIDTH=1
  logic       s2_iv = 1'b0, s2_ir, s2_ov, s2_or = 1'b1;
  logic [1:0] s2_a = '0, s2_b = '0, s2_c;
  logic [0:0] s2_r = '0, s2_p = '0;

  masked_hpc3_mult_pipe #(.SHARES(2), .WIDTH(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(s2_iv), .in_ready(s2_ir),
    .a(s2_a), .b(s2_b), .r(s2_r), .p(s2_p),
    .out_valid(s2_ov), .out_ready(s2_or), .c(s2_c)
  );

  // SHARES=5, WIDTH=16
  logic         s5_iv = 1'b0, s5_ir, s5_ov, s5_or = 1'b1;
  logic [79:0]  s5_a = '0, s5_b = '0, s5_c;
  logic [159:0] s5_r = '0, s5_p = '0;

  masked_hpc3_mult_pipe #(.SHARES(5), .WIDTH(16)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(s5_iv), .in_ready(s5_ir),
    .a(s5_a), .b(s5_b), .r(s5_r), .p(s5_p),
    .out_valid(s5_ov), .out_ready(s5_or), .c(s5_c)
  );

  int n_total = 0;
  int n_bad   = 0;
  int n_out   = 0;
  int n_out2  = 0;
  int n_out5  = 0;

  logic [7:0]  exp_q [$];
  logic [0:0]  q2    [$];
  logic [15:0] q5    [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fold4(input logic [31:0] x);
    return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
  endfunction

  function automatic logic [0:0] fold2(input logic [1:0] x);
    return x[0] ^ x[1];
  endfunction

  function automatic logic [15:0] fold5(input logic [79:0] x);
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < 5; i++) f = f ^ x[i*16 +: 16];
    return f;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // Scoreboards: inputs/handshakes are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      q2.delete();
      q5.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(fold4(a) & fold4(b));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("spurious_out", 64'(1), 64'(0));
        else chk("sb_xor_c", 64'(fold4(c)), 64'(exp_q.pop_front()));
      end
      if (s2_iv && s2_ir) q2.push_back(fold2(s2_a) & fold2(s2_b));
      if (s2_ov && s2_or) begin
        n_out2++;
        if (q2.size() == 0) chk("sw2_spurious", 64'(1), 64'(0));
        else chk("sw2_xor_c", 64'(fold2(s2_c)), 64'(q2.pop_front()));
      end
      if (s5_iv && s5_ir) q5.push_back(fold5(s5_a) & fold5(s5_b));
      if (s5_ov && s5_or) begin
        n_out5++;
        if (q5.size() == 0) chk("sw5_spurious", 64'(1), 64'(0));
        else chk("sw5_xor_c", 64'(fold5(s5_c)), 64'(q5.pop_front()));
      end
    end
  end

  // Offer one beat and hold it until accepted, bounded.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                      input logic [47:0] tr, input logic [47:0] tp);
    logic got;
    int   n;
    a = ta; b = tb; r = tr; p = tp;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 64);
    if (!got) chk("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  // Single beat into an empty pipe: result visible two edges after it is offered.
  task automatic one_beat(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic [47:0] tr, input logic [47:0] tp,
                          input logic [31:0] exp_c, input logic [7:0] exp_x);
    a = ta; b = tb; r = tr; p = tp;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk({tag, "_ov"}, 64'(out_valid), 64'(1));
    chk({tag, "_c"}, 64'(c), 64'(exp_c));
    chk({tag, "_x"}, 64'(fold4(c)), 64'(exp_x));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  logic [31:0] hold_c;
  logic [7:0]  first_c0;
  logic        have_c0;
  logic        varied;
  int          n0;

  initial begin
    // Reset held for 3 cycles with random inputs
    for (int k = 0; k < 3; k++) begin
      a = $urandom; b = $urandom; r = rand48(); p = rand48();
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_ov", 64'(out_valid), 64'(0));
      chk("rst_c", 64'(c), 64'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // a XOR = 4B; b XOR 00 / FF; r, p chosen so every share is predictable
    one_beat("v_b00", 32'h3B563412, 32'h55AA0FF0, 48'h0, 48'h0, 32'h00000000, 8'h00);
    one_beat("v_bff", 32'h3B563412, 32'hAAAA0FF0, 48'h0, 48'h0, 32'h3B563412, 8'h4B);
    one_beat("v_r1s", 32'h3B563412, 32'hAAAA0FF0, {48{1'b1}}, 48'h0, 32'hC4A9CBED, 8'h4B);
    one_beat("v_p1s", 32'h3B563412, 32'h55AA0FF0, 48'h0, {48{1'b1}}, 32'hFFFFFFFF, 8'h00);

    // Randomness independence: result fixed, shares vary
    n0 = n_out;
    have_c0 = 1'b0;
    varied = 1'b0;
    a = 32'h3B563412; b = 32'hAAAA0FF0;
    in_valid = 1'b1;
    for (int k = 0; k < 103; k++) begin
      if (k == 100) in_valid = 1'b0;
      r = rand48(); p = rand48();
      @(posedge clk); #1;
      if (out_valid) begin
        if (!have_c0) begin
          first_c0 = c[7:0];
          have_c0 = 1'b1;
        end else if (c[7:0] != first_c0) begin
          varied = 1'b1;
        end
      end
    end
    chk("rand_count", 64'(n_out - n0), 64'(100));
    chk("rand_varies", 64'(varied), 64'(1));

    // Back-pressure: 5 beats, output stalled for 4 cycles once both stages fill
    n0 = n_out;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++)
          send(32'h3B563400 | 32'(k), 32'hAAAA0FF0, rand48(), rand48());
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("bp_full_ov", 64'(out_valid), 64'(1));
        chk("bp_full_ir", 64'(in_ready), 64'(0));
        hold_c = c;
        repeat (4) begin
          @(posedge clk); #1;
          chk("bp_hold_c", 64'(c), 64'(hold_c));
          chk("bp_hold_ir", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("bp_count", 64'(n_out - n0), 64'(5));
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // Reset with two beats in flight: neither may ever be delivered
    n0 = n_out;
    out_ready = 1'b0;
    send(32'h11223344, 32'hFFFF00FF, rand48(), rand48());
    send(32'h55667788, 32'hFF00FF00, rand48(), rand48());
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ov", 64'(out_valid), 64'(0));
    chk("mrst_c", 64'(c), 64'(0));
    chk("mrst_ir", 64'(in_ready), 64'(1));
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mrst_none", 64'(n_out - n0), 64'(0));
    chk("mrst_ov_after", 64'(out_valid), 64'(0));

    // Parameter sweep against (XOR a) & (XOR b)
    for (int k = 0; k < 10000; k++) begin
      s2_iv = 1'($urandom);
      s2_or = ($urandom_range(0, 3) != 0);
      s2_a = 2'($urandom); s2_b = 2'($urandom);
      s2_r = 1'($urandom); s2_p = 1'($urandom);
      s5_iv = 1'($urandom);
      s5_or = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5; i++) begin
        s5_a[i*16 +: 16] = 16'($urandom);
        s5_b[i*16 +: 16] = 16'($urandom);
      end
      for (int i = 0; i < 10; i++) begin
        s5_r[i*16 +: 16] = 16'($urandom);
        s5_p[i*16 +: 16] = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    s2_iv = 1'b0; s5_iv = 1'b0;
    s2_or = 1'b1; s5_or = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("sw2_drained", 64'(q2.size()), 64'(0));
    chk("sw5_drained", 64'(q5.size()), 64'(0));
    chk("sw2_active", 64'(n_out2 > 1000), 64'(1));
    chk("sw5_active", 64'(n_out5 > 1000), 64'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
